// File: rtl/serial_tx.sv
// serial_tx: LSB-first serializer framing each word with a start bit and a stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              q,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic q_q, ready_q, busy_q, done_q;
  logic tick;
`ifdef SERIAL_TX_PARITY_EN
  logic par_q;
`endif
  assign tick = cnt_q == '0;
  assign sh_d = sh_q >> 1;
  assign tx_ready = ready_q;
  assign q = q_q;
  assign busy = busy_q;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      q_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      // tick marks the last cycle of the current bit; the counter reloads there
      cnt_q  <= tick ? RELOAD : cnt_q - 1'b1;
      case (state_q)
        IDLE: if (tx_valid && ready_q) begin
          state_q <= START;
          sh_q    <= tx_data;
          cnt_q   <= RELOAD;
          bit_q   <= '0;
          q_q     <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          par_q   <= ^tx_data;
`endif
        end
        START: if (tick) begin
          state_q <= DATA;
          q_q     <= sh_q[0];
        end
        DATA: if (tick) begin
          if (bit_q == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_q <= PARITY;
            q_q     <= par_q;
`else
            state_q <= STOP;
            q_q     <= 1'b1;
`endif
          end else begin
            bit_q <= bit_q + 1'b1;
            sh_q  <= sh_d;
            q_q   <= sh_d[0];
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: if (tick) begin
          state_q <= STOP;
          q_q     <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
